// File: rtl/weight_bank_buffer_pkg.sv
// Shared definitions for the weight bank buffer.
//  RD_SINGLE / RD_WIDE : read mode encodings carried in the pipeline tag
//  clog2()             : ceiling log2 for parameter math
//  fifo_depth()        : response FIFO depth for a given RAM latency
package weight_bank_buffer_pkg;

  localparam logic RD_SINGLE = 1'b0;
  localparam logic RD_WIDE   = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // One slot per pipeline stage plus one, so a full RAM pipeline can always
  // drain while the consumer stalls.
  function automatic int fifo_depth(input int n_delay);
    return n_delay + 1;
  endfunction

endpackage

// File: rtl/weight_bank_buffer_rsp_fifo.sv
// weight_rsp_fifo: fall-through response FIFO.
//  When empty, in_* bypasses straight to out_* so no cycle is added.
//  out_data is forced to 0 whenever out_valid is low.
// Ports
//  clk, rstn            clock, async active-low reset
//  in_valid/in_ready    push handshake, in_data W bits
//  out_valid/out_ready  pop handshake, out_data W bits
//  count                stored entries (not counting a bypassed word)
module weight_rsp_fifo
  import weight_bank_buffer_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 2,
  localparam int CW = clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  localparam int PW = (clog2(D) > 0) ? clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wp, rp;
  logic          empty, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign in_ready  = (count < CW'(D));
  assign out_valid = ~empty | in_valid;
  assign pop       = ~empty & out_ready;
  // A word consumed straight through the bypass never gets stored.
  assign push      = in_valid & in_ready & ~(empty & out_ready);

  always_comb begin
    out_data = '0;
    if (!empty)        out_data = mem[rp];
    else if (in_valid) out_data = in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end

endmodule

// File: rtl/weight_bank_buffer.sv
// weight_bank_buffer: N_BANK single-port weight banks feeding the PE array.
//  Writes always win a bank; a read is held off when it would touch the bank
//  being written (any bank for a wide read). Reads travel an N_DELAY-cycle
//  pipeline with a (wide, bank) tag and land in a fall-through response FIFO.
//  Credit (in-pipeline + stored) never exceeds the FIFO depth, so the
//  pipeline never has to stall.
// Ports
//  clk, rstn                    clock, async active-low reset
//  wr_valid/wr_ready            write request, wr_addr={row,bank}, wr_data
//  rd_valid/rd_ready            read request, rd_addr={row,bank}, rd_wide
//  rsp_valid/rsp_ready          response, rsp_data (lane b = bank b when wide,
//                               lane 0 when single), rsp_perr
// Build option
//  WEIGHT_PARITY_EN : store an even-parity bit per word and report mismatches
//                     on rsp_perr; perr_inject[0] flips the stored bit on write.
module weight_bank_buffer
  import weight_bank_buffer_pkg::*;
#(
  parameter int DW      = 128,
  parameter int AW_BANK = 4,
  parameter int N_BANK  = 4,
  parameter int N_DELAY = 1,
  localparam int BW = clog2(N_BANK),
  localparam int AW = AW_BANK + BW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 rd_wide,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N_BANK*DW-1:0] rsp_data,
  output logic                 rsp_perr
);

  localparam int DEPTH  = 1 << AW_BANK;
  localparam int FIFO_D = fifo_depth(N_DELAY);
  localparam int CW     = clog2(FIFO_D + 1);
  localparam int BWS    = (BW > 0) ? BW : 1;
  localparam int FW     = N_BANK * DW + 1;
`ifdef WEIGHT_PARITY_EN
  localparam int MW = DW + 1;
  logic [0:0] perr_inject;
  assign perr_inject = 1'b0;
`else
  localparam int MW = DW;
`endif

  logic [BWS-1:0]     wr_bank, rd_bank;
  logic [AW_BANK-1:0] wr_row, rd_row;

  if (BW > 0) begin : g_bank_idx
    assign wr_bank = wr_addr[BWS-1:0];
    assign rd_bank = rd_addr[BWS-1:0];
  end else begin : g_one_bank
    assign wr_bank = '0;
    assign rd_bank = '0;
  end
  assign wr_row = wr_addr[AW-1:BW];
  assign rd_row = rd_addr[AW-1:BW];

  // Handshake and credit
  logic          wr_fire, rd_fire, conflict, fifo_in_ready;
  logic [CW-1:0] fifo_cnt, outstanding;

  assign wr_ready = rstn;
  assign wr_fire  = wr_valid & wr_ready;
  assign conflict = wr_fire & ((rd_wide == RD_WIDE) | (rd_bank == wr_bank));
  // fifo_in_ready is implied by the credit check; kept as a guard.
  assign rd_ready = rstn & ~conflict & fifo_in_ready &
                    ((int'(outstanding) + int'(fifo_cnt)) < FIFO_D);
  assign rd_fire  = rd_valid & rd_ready;

  // Read pipeline valids and tags
  logic [N_DELAY-1:0]          vld_pipe;
  logic [N_DELAY-1:0]          wide_pipe;
  logic [N_DELAY-1:0][BWS-1:0] bank_pipe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= rd_fire;
      for (int i = 1; i < N_DELAY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    wide_pipe[0] <= rd_wide;
    bank_pipe[0] <= rd_bank;
    for (int i = 1; i < N_DELAY; i++) begin
      wide_pipe[i] <= wide_pipe[i-1];
      bank_pipe[i] <= bank_pipe[i-1];
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < N_DELAY; i++) outstanding = outstanding + CW'(vld_pipe[i]);
  end

  // Banks: sync read into stage 0, then N_DELAY-1 shift stages
  logic [N_BANK-1:0][MW-1:0] bank_q;

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    logic [MW-1:0]              mem [DEPTH];
    logic [N_DELAY-1:0][MW-1:0] dpipe;
    logic [MW-1:0]              wword;
`ifdef WEIGHT_PARITY_EN
    assign wword = {(^wr_data) ^ perr_inject[0], wr_data};
`else
    assign wword = wr_data;
`endif
    always_ff @(posedge clk) begin
      if (wr_fire && wr_bank == BWS'(b)) mem[wr_row] <= wword;
      if (rd_fire && (rd_wide == RD_WIDE || rd_bank == BWS'(b))) dpipe[0] <= mem[rd_row];
      for (int i = 1; i < N_DELAY; i++) dpipe[i] <= dpipe[i-1];
    end
    assign bank_q[b] = dpipe[N_DELAY-1];
  end

  // Lane placement at the FIFO input, steered by the tag
  logic                      pwide;
  logic [BWS-1:0]            pbank;
  logic [N_BANK-1:0][DW-1:0] lane_d;
  logic                      perr_d;
  logic [FW-1:0]             fifo_out;

  assign pwide = wide_pipe[N_DELAY-1];
  assign pbank = bank_pipe[N_DELAY-1];

  always_comb begin
    lane_d = '0;
    perr_d = 1'b0;
    for (int b = 0; b < N_BANK; b++) begin
      if (pwide == RD_WIDE) lane_d[b] = bank_q[b][DW-1:0];
      else if (pbank == BWS'(b)) lane_d[0] = bank_q[b][DW-1:0];
`ifdef WEIGHT_PARITY_EN
      // Stored word + parity bit XOR to 0 when intact.
      if (pwide == RD_WIDE || pbank == BWS'(b)) perr_d = perr_d | (^bank_q[b]);
`endif
    end
  end

  weight_rsp_fifo #(.W(FW), .D(FIFO_D)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (vld_pipe[N_DELAY-1]),
    .in_ready  (fifo_in_ready),
    .in_data   ({perr_d, lane_d}),
    .out_valid (rsp_valid),
    .out_ready (rsp_ready),
    .out_data  (fifo_out),
    .count     (fifo_cnt)
  );

  assign {rsp_perr, rsp_data} = fifo_out;

endmodule

// File: tb/tb_weight_bank_buffer.sv
module tb_weight_bank_buffer;
  localparam int DW = 128, AW_BANK = 4, N_BANK = 4, N_DELAY = 1;
  localparam int AW = AW_BANK + 2, RW = N_BANK * DW, FIFO_D = N_DELAY + 1;

  typedef struct {
    logic [RW-1:0] data;
    logic          perr;
    int            due;
  } rsp_t;

  logic          clk = 1'b0, rstn = 1'b0;
  logic          wr_valid = 1'b0, rd_valid = 1'b0, rd_wide = 1'b0, rsp_ready = 1'b1;
  logic          wr_ready, rd_ready, rsp_valid, rsp_perr;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [RW-1:0] rsp_data;

  always #5 clk = ~clk;

  weight_bank_buffer #(.DW(DW), .AW_BANK(AW_BANK), .N_BANK(N_BANK), .N_DELAY(N_DELAY)) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_wide(rd_wide),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_perr(rsp_perr)
  );

  // Reference model: flat word array, per-word injected-parity flag, and a
  // queue of accepted reads with the cycle their response becomes due.
  logic [DW-1:0] mem_m [1 << AW];
  bit            pflag [1 << AW];
  rsp_t          q [$];
  int            cyc, n_vec, n_err;
  bit            inj;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int r, input int b);
    return {8{8'h00, 4'(r), 4'(b)}};
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic rsp_t model_read(input logic [AW-1:0] a, input logic w);
    rsp_t r;
    r.data = '0;
    r.perr = 1'b0;
    r.due  = cyc + N_DELAY;
    if (w) begin
      for (int b = 0; b < N_BANK; b++) begin
        r.data[b*DW +: DW] = mem_m[{a[AW-1:2], 2'(b)}];
        r.perr = r.perr | pflag[{a[AW-1:2], 2'(b)}];
      end
    end else begin
      r.data[DW-1:0] = mem_m[a];
      r.perr = pflag[a];
    end
`ifndef WEIGHT_PARITY_EN
    r.perr = 1'b0;
`endif
    return r;
  endfunction

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra, input logic rw);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rd_wide = rw;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic exp_rdy, exp_vld;
    #1;
    exp_rdy = !(wr_valid && (rd_wide || rd_addr[1:0] == wr_addr[1:0])) && (q.size() < FIFO_D);
    exp_vld = (q.size() > 0) && (q[0].due <= cyc);
    chk("wr_ready", wr_ready, 1'b1);
    chk("rd_ready", rd_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_vld);
    if (exp_vld) begin
      if (rsp_valid) begin
        chk("rsp_data", rsp_data, q[0].data);
        chk("rsp_perr", rsp_perr, q[0].perr);
      end
      if (rsp_ready) void'(q.pop_front());
    end
    if (rd_valid && exp_rdy) q.push_back(model_read(rd_addr, rd_wide));
    if (wr_valid) begin
      mem_m[wr_addr] = wr_data;
      pflag[wr_addr] = inj;
    end
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_perr", rsp_perr, 1'b0);
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    repeat (n) step();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; inj = 1'b0;
    #2;
    chk_reset_outputs();
    @(negedge clk);
    #1;
    rstn = 1'b1;

    // Fill every word with its {row,bank} pattern
    for (int r = 0; r < 16; r++)
      for (int b = 0; b < N_BANK; b++) begin
        drive(1'b1, {4'(r), 2'(b)}, pat(r, b), 1'b0, '0, 1'b0);
        step();
      end

    // Single read of row 9 bank 1
    drive(1'b0, '0, '0, 1'b1, 6'h25, 1'b0);
    step();
    idle(3);

    // Wide read of row 9 blocked by a bank-2 write, then accepted
    drive(1'b1, {4'd3, 2'd2}, rnd128(), 1'b1, {4'd9, 2'd0}, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b1, {4'd9, 2'd0}, 1'b1);
    step();
    idle(3);

    // Parallel read/write on different banks, then read-after-write
    drive(1'b1, {4'd7, 2'd3}, rnd128(), 1'b1, {4'd5, 2'd0}, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, {4'd7, 2'd3}, 1'b0);
    step();
    idle(3);

    // Backpressure: 5 read attempts with the consumer stalled
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b1, 6'($urandom), 1'($urandom));
      step();
    end
    idle(3);
    rsp_ready = 1'b1;
    idle(4);

    // Reset with reads pending and the consumer stalled
    rsp_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 6'($urandom), 1'b0);
    step();
    step();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    rstn = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete();
    @(negedge clk);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    rsp_ready = 1'b1;
    idle(3);

    // Parity inject on the write to 0x10, then read 0x10 and 0x11
    inj = 1'b1;
`ifdef WEIGHT_PARITY_EN
    force dut.perr_inject = 1'b1;
`endif
    drive(1'b1, 6'h10, rnd128(), 1'b0, '0, 1'b0);
    step();
`ifdef WEIGHT_PARITY_EN
    release dut.perr_inject;
`endif
    inj = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 6'h10, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 6'h11, 1'b0);
    step();
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 6'($urandom), rnd128(), 1'($urandom), 6'($urandom),
            ($urandom_range(0, 3) == 0));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    idle(6);
    chk("drain_empty", RW'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
